// File: rtl/weights_pkg.sv
// Shared constants and state encoding for the weight RAM loader.
package weights_pkg;

  localparam int WEIGHT_N     = 8;
  localparam int WEIGHT_Q     = 7;
  localparam int WEIGHT_DEPTH = 256;
  localparam int WEIGHT_AW    = 8;
  localparam int CSUM_W       = 16;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_FIN  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/weights_loader_if.sv
// Stream-in / RAM-write-out bundle of the weights loader.
// master: upstream stream source and RAM observer; slave: the loader itself.
interface weights_loader_if #(
  parameter int N  = weights_pkg::WEIGHT_N,
  parameter int AW = weights_pkg::WEIGHT_AW
);

  logic                 s_valid;
  logic [N-1:0]         s_data;
  logic                 s_ready;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [N-1:0]  wr_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/weights_loader.sv
// Start-triggered stream-to-RAM writer for the fixed-point weight memory.
// Optional running checksum of written words: define WEIGHTS_LOADER_CSUM_EN.
module weights_loader
  import weights_pkg::*;
#(
  parameter int N     = WEIGHT_N,
  parameter int Q     = WEIGHT_Q,
  parameter int DEPTH = WEIGHT_DEPTH,
  parameter int AW    = WEIGHT_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW:0]       count,
  weights_loader_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CSUM_W-1:0] csum
);

  if (Q < 0 || Q >= N || (1 << AW) < DEPTH) begin : g_bad_params
    $error("weights_loader: illegal N/Q/DEPTH/AW combination");
  end

  localparam logic [1:0]    S_IDLE    = LD_IDLE;
  localparam logic [1:0]    S_LOAD    = LD_LOAD;
  localparam logic [1:0]    S_FIN     = LD_FIN;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]          state_reg, state_next;
  logic [AW-1:0]       addr_reg;
  logic [AW:0]         remaining_reg;
  logic                wr_en_reg;
  logic [AW-1:0]       wr_addr_reg;
  logic signed [N-1:0] wr_data_reg;
  logic                err_reg;

  logic handshake;
  logic start_load;
  logic start_empty;
  logic start_bad;
  logic last_word;

  assign start_load  = (state_reg == S_IDLE) && start && (count != '0) && (count <= DEPTH_CNT);
  assign start_empty = (state_reg == S_IDLE) && start && (count == '0);
  assign start_bad   = (state_reg == S_IDLE) && start && (count > DEPTH_CNT);

  assign handshake = bus.s_valid && bus.s_ready;
  assign last_word = (remaining_reg == (AW+1)'(1));

  assign bus.s_ready = (state_reg == S_LOAD);
  assign busy        = (state_reg == S_LOAD);
  // FIN is entered on the cycle the final registered write becomes visible
  assign done        = (state_reg == S_FIN);
  assign err         = err_reg;

  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_load) begin
          state_next = S_LOAD;
        end else if (start_empty) begin
          state_next = S_FIN;
        end
      end
      S_LOAD: begin
        if (handshake && last_word) begin
          state_next = S_FIN;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= start_bad;
      wr_en_reg <= handshake;
      if (start_load) begin
        addr_reg      <= base_addr;
        remaining_reg <= count;
      end else if (handshake) begin
        wr_addr_reg   <= addr_reg;
        wr_data_reg   <= bus.s_data;
        addr_reg      <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + AW'(1);
        remaining_reg <= remaining_reg - (AW+1)'(1);
      end
    end
  end

`ifdef WEIGHTS_LOADER_CSUM_EN
  logic [CSUM_W-1:0] csum_reg;

  // Accumulates from the registered write, so the sum lags each write by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_reg <= '0;
    end else if (start_load) begin
      csum_reg <= '0;
    end else if (wr_en_reg) begin
      csum_reg <= csum_reg + CSUM_W'(wr_data_reg);
    end
  end

  assign csum = csum_reg;
`else
  assign csum = '0;
`endif

endmodule
